// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: one shift-add or
// restoring-divide step per clock, XLEN steps, then a one-cycle done pulse.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_f3;
  logic [4:0]          r_rd;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic                r_neg;
  logic [2*XLEN-1:0]   r_prod;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quo;

  logic                w_a_sgn;
  logic                w_b_sgn;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic                w_res_neg;
  logic                w_accept;
  logic                w_last;
  logic [XLEN-1:0]     w_add;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_prod_nxt;
  logic [XLEN:0]       w_shift;
  logic [XLEN:0]       w_diff;
  logic                w_ge;
  logic [XLEN-1:0]     w_rem_nxt;
  logic [XLEN-1:0]     w_quo_nxt;
  logic [2*XLEN-1:0]   w_prod_fin;
  logic [XLEN-1:0]     w_rem_fin;
  logic [XLEN-1:0]     w_quo_fin;
  logic [XLEN-1:0]     w_result;

  // Operand signedness from funct3: MULHU/DIVU/REMU are fully unsigned,
  // MULHSU treats only rs1 as signed.
  always_comb begin
    w_a_sgn   = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    w_b_sgn   = w_a_sgn && (funct3 != 3'b010);
    w_a_neg   = w_a_sgn && op_a[XLEN-1];
    w_b_neg   = w_b_sgn && op_b[XLEN-1];
    w_a_mag   = w_a_neg ? ({XLEN{1'b0}} - op_a) : op_a;
    w_b_mag   = w_b_neg ? ({XLEN{1'b0}} - op_b) : op_b;
    w_res_neg = 1'b0;
    if (!funct3[2]) begin
      w_res_neg = w_a_neg ^ w_b_neg;
    end else if (!funct3[1]) begin
      // A zero divisor must yield all ones, so the quotient is never negated.
      w_res_neg = (w_a_neg ^ w_b_neg) && (op_b != '0);
    end else begin
      w_res_neg = w_a_neg;
    end
  end

  assign w_accept = start && !kill && (r_state != S_CALC);
  assign w_last   = (r_cnt == CNT_W'(XLEN - 1));

  // Both datapaths step every CALC cycle; funct3 picks which one is reported.
  always_comb begin
    w_add      = r_prod[0] ? r_a : '0;
    w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, w_add};
    w_prod_nxt = {w_sum, r_prod[XLEN-1:1]};
    w_shift    = {r_rem, r_quo[XLEN-1]};
    w_diff     = w_shift - {1'b0, r_b};
    w_ge       = !w_diff[XLEN];
    w_rem_nxt  = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    w_quo_nxt  = {r_quo[XLEN-2:0], w_ge};
  end

  always_comb begin
    w_prod_fin = r_neg ? ({(2*XLEN){1'b0}} - w_prod_nxt) : w_prod_nxt;
    w_quo_fin  = r_neg ? ({XLEN{1'b0}} - w_quo_nxt) : w_quo_nxt;
    w_rem_fin  = r_neg ? ({XLEN{1'b0}} - w_rem_nxt) : w_rem_nxt;
    case (r_f3)
      3'b000:                 w_result = w_prod_fin[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_result = w_prod_fin[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_result = w_quo_fin;
      default:                w_result = w_rem_fin;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_f3    <= '0;
      r_rd    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_neg   <= 1'b0;
      r_prod  <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_state <= S_CALC;
        r_cnt   <= '0;
        r_f3    <= funct3;
        r_rd    <= rd_in;
        r_a     <= w_a_mag;
        r_b     <= w_b_mag;
        r_neg   <= w_res_neg;
        r_prod  <= {{XLEN{1'b0}}, w_b_mag};
        r_rem   <= '0;
        r_quo   <= w_a_mag;
        busy    <= 1'b1;
      end else begin
        case (r_state)
          S_CALC: begin
            if (kill) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              r_prod <= w_prod_nxt;
              r_rem  <= w_rem_nxt;
              r_quo  <= w_quo_nxt;
              r_cnt  <= r_cnt + CNT_W'(1);
              if (w_last) begin
                r_state <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                result  <= w_result;
                rd_out  <= r_rd;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M corner cases plus
// randomized operations against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_tests;
  int n_fail;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      4:       return 32'd0 - 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Drives start for one edge, then scrambles the operand inputs; returns at
  // the first falling edge after the accepting edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_in  = tag;
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
    rd_in  = 5'($urandom);
  endtask

  task automatic wait_done(input int lat0, output int lat, output int busy_cycles);
    lat = lat0;
    busy_cycles = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic watch_no_done(input string name);
    bit seen;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: unexpected busy/done activity, got 1 expected 0", name);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                        input bit check_timing);
    int lat, bc;
    issue(f, a, b, tag);
    wait_done(1, lat, bc);
    if (check_timing) begin
      n_tests++;
      if (lat !== 33) begin
        n_fail++;
        $display("FAIL %s latency: got %0d expected 33", name, lat);
      end
      n_tests++;
      if (bc !== 32) begin
        n_fail++;
        $display("FAIL %s busy cycles: got %0d expected 32", name, bc);
      end
    end
    n_tests++;
    if (result !== exp) begin
      n_fail++;
      $display("FAIL %s result: got %h expected %h (f3=%0d a=%h b=%h)", name, result, exp, f, a, b);
    end
    n_tests++;
    if (rd_out !== tag) begin
      n_fail++;
      $display("FAIL %s rd_out: got %0d expected %0d", name, rd_out, tag);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s return to idle: got done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, result, rd_out} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got busy=%b done=%b result=%h rd_out=%0d expected all 0",
               busy, done, result, rd_out);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op("mul_7x-3",   3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB, 1'b1);
    run_op("mulh",       3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 1'b1);
    run_op("mulhsu",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2,  32'h8000_0000, 1'b1);
    run_op("mulhu",      3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3,  32'h7FFF_FFFF, 1'b1);
    run_op("div_-7/2",   3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD, 1'b1);
    run_op("rem_-7%2",   3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFF, 1'b1);
    run_op("divu",       3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 5'd6,  32'h0FFF_FFFF, 1'b1);
    run_op("remu",       3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 5'd7,  32'h0000_000F, 1'b1);
    run_op("div_by_0",   3'd4, 32'h0000_0005, 32'h0000_0000, 5'd8,  32'hFFFF_FFFF, 1'b1);
    run_op("rem_by_0",   3'd6, 32'h0000_0005, 32'h0000_0000, 5'd9,  32'h0000_0005, 1'b1);
    run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1);
    run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1'b1);
    run_op("div_neg_0",  3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 5'd13, 32'hFFFF_FFFF, 1'b1);
    run_op("rem_neg_0",  3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 5'd14, 32'hFFFF_FFF9, 1'b1);
    run_op("remu_by_0",  3'd7, 32'h8765_4321, 32'h0000_0000, 5'd15, 32'h8765_4321, 1'b1);
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom);
      a = rand_val();
      b = rand_val();
      run_op("random", f, a, b, 5'($urandom), model(f, a, b), (i % 8) == 0);
    end
  endtask

  task automatic test_start_in_calc();
    int lat, bc;
    issue(3'd0, 32'd1234, 32'd5678, 5'd20);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd5;
    op_a   = 32'd100;
    op_b   = 32'd7;
    rd_in  = 5'd21;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat, bc);
    n_tests++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL start_in_calc latency: got %0d expected 33", lat);
    end
    n_tests++;
    if (result !== 32'd7006652 || rd_out !== 5'd20) begin
      n_fail++;
      $display("FAIL start_in_calc result: got %h/%0d expected %h/20", result, rd_out, 32'd7006652);
    end
    @(negedge clk);
  endtask

  task automatic test_kill();
    logic [31:0] prev;
    prev = result;
    issue(3'd1, $urandom, $urandom, 5'd22);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_calc idle: got busy=%b done=%b expected 0 0", busy, done);
    end
    watch_no_done("kill_calc");
    n_tests++;
    if (result !== prev) begin
      n_fail++;
      $display("FAIL kill_calc result held: got %h expected %h", result, prev);
    end
  endtask

  task automatic test_kill_with_start();
    int lat, bc;
    logic [31:0] prev;
    issue(3'd7, 32'd1000, 32'd33, 5'd23);
    wait_done(1, lat, bc);
    prev = result;
    n_tests++;
    if (prev !== 32'd10) begin
      n_fail++;
      $display("FAIL kill_start setup result: got %h expected %h", prev, 32'd10);
    end
    kill   = 1'b1;
    start  = 1'b1;
    funct3 = 3'd0;
    op_a   = 32'd3;
    op_b   = 32'd3;
    rd_in  = 5'd24;
    @(negedge clk);
    kill  = 1'b0;
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_start idle: got busy=%b done=%b expected 0 0", busy, done);
    end
    watch_no_done("kill_start");
    n_tests++;
    if (result !== prev) begin
      n_fail++;
      $display("FAIL kill_start result held: got %h expected %h", result, prev);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(3'd0, 32'd9, 32'd9, 5'd25);
    wait_done(1, lat, bc);
    n_tests++;
    if (result !== 32'd81 || rd_out !== 5'd25) begin
      n_fail++;
      $display("FAIL b2b first: got %h/%0d expected %h/25", result, rd_out, 32'd81);
    end
    issue(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd26);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b accept: got done=%b busy=%b expected 0 1", done, busy);
    end
    wait_done(1, lat, bc);
    n_tests++;
    if (lat !== 33 || bc !== 32) begin
      n_fail++;
      $display("FAIL b2b timing: got lat=%0d busy=%0d expected 33 32", lat, bc);
    end
    n_tests++;
    if (result !== 32'hFFFF_FFFE || rd_out !== 5'd26) begin
      n_fail++;
      $display("FAIL b2b second: got %h/%0d expected %h/26", result, rd_out, 32'hFFFF_FFFE);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    issue(3'd4, 32'd5000, 32'd3, 5'd27);
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, result, rd_out} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: got busy=%b done=%b result=%h rd_out=%0d expected all 0",
               busy, done, result, rd_out);
    end
    @(negedge clk);
    reset = 1'b1;
    watch_no_done("reset_mid");
    n_tests++;
    if (result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid result: got %h expected 0", result);
    end
    run_op("after_reset", 3'd4, 32'd5000, 32'd3, 5'd28, 32'd1666, 1'b1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    start   = 1'b0;
    kill    = 1'b0;
    funct3  = '0;
    op_a    = '0;
    op_b    = '0;
    rd_in   = '0;
    test_reset();
    test_directed();
    test_random();
    test_start_in_calc();
    test_kill();
    test_kill_with_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, downstream of the ID/EX pipeline register.
- Consumes the latched operands (EX_Read_data_1/2), funct3 and rd when the EX stage decodes an M-extension R-type instruction (funct7 = 0000001).
- Asserts busy so the hazard logic stalls IF/ID/EX, then presents a registered result with a one-cycle done pulse to the EX/MEM path.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on the rising edge of clk.
- kill  input  1  pipeline flush; aborts the current operation.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value (multiplicand/dividend).
- op_b  input  XLEN  rs2 value (multiplier/divisor).
- rd_in  input  5  destination register tag.
- busy  output  1  high while iterating; used as the pipeline stall.
- done  output  1  one-cycle result-valid pulse.
- result  output  XLEN  registered result; holds its value until the next done.
- rd_out  output  5  tag captured at start; valid with done.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0, internal accumulators=0. Reset mid-operation discards the operation; no done follows.
- FSM states: IDLE, CALC, DONE.
- busy=1 only in CALC. done=1 only in DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE. Accepting in DONE gives back-to-back operation.
  - start is ignored in CALC.
  - On acceptance: capture funct3 and rd_in. Capture |op_a| and |op_b| (two's-complement magnitude, per the signedness of funct3). Record the result sign. Clear the counter. Go to CALC.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU and DIVU/REMU: both unsigned.
  - DIV/REM: both signed.
  - Division result signs: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- CALC iterations: one iteration per clock, XLEN iterations exactly.
  - Multiply: shift-add into a 2*XLEN-bit product.
  - Divide: restoring division, producing one quotient bit per cycle.
- Exit from CALC: on the edge that completes iteration XLEN, go to DONE. On that same edge, register result, apply sign correction (2*XLEN negate for multiply), and drive rd_out.
- Latency: start sampled at edge N → busy high for cycles N..N+XLEN-1 → done high for exactly one cycle after edge N+XLEN (33 cycles start-to-done for XLEN=32).
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Divide by zero (op_b=0): DIV/DIVU → all ones (0xFFFFFFFF); REM/REMU → op_a unchanged. Latency stays the full XLEN.
- Signed overflow (DIV with op_a=0x80000000, op_b=0xFFFFFFFF): quotient 0x80000000, REM 0. Full latency.
- kill:
  - In CALC or DONE: go to IDLE next edge and suppress done. result keeps its previous value.
  - Priority: kill beats start on the same edge.
  - In IDLE: no effect.
- After DONE with no start: return to IDLE; done deasserts.
- op_a, op_b and funct3 may change freely during CALC; only the values captured at start are used.

Test Plan:
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD): busy high for 32 cycles, done on cycle 33, result=0xFFFFFFEB, rd_out=captured tag.
- MULH/MULHSU/MULHU with 0x80000000 × 0xFFFFFFFF: MULH=0x00000000, MULHSU=0x80000000, MULHU=0x7FFFFFFF.
- DIV -7/2 = 0xFFFFFFFD and REM -7%2 = 0xFFFFFFFF. DIVU 0xFFFFFFFF/0x10 = 0x0FFFFFFF and REMU = 0xF.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF, REM 5%0 → 5. Overflow DIV 0x80000000/-1 → 0x80000000, REM → 0. All at 33-cycle latency.
- kill asserted at cycle 10 of CALC → IDLE next cycle, no done, result unchanged. start asserted with kill on the same edge → ignored. start during CALC → ignored.
- Back-to-back: start held in DONE → new operation accepted with done high for one cycle. Assert reset at cycle 15 of CALC → all outputs 0 immediately; no done after release.
